inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Instruction-fetch stage directly downstream of the program counter in the IFU. Accepts the next instruction address, issues one request at a time to instruction memory, and buffers returned `{pc, instruction}` pairs in a small FIFO for decode. A flush input handles branch/jump redirects: it discards queued entries and any response still in flight.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_addr`  in  32  next instruction address from the program counter.
- `pc_valid`  in  1  `pc_addr` is valid.
- `pc_ready`  out  1  address consumed this cycle; the PC advances on `pc_valid && pc_ready`.
- `imem_req`  out  1  memory request.
- `imem_addr`  out  32  request address.
- `imem_gnt`  in  1  request accepted.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response instruction word.
- `flush`  in  1  redirect; discard queue and in-flight response.
- `dec_valid`  out  1  head entry valid.
- `dec_inst`  out  32  head instruction.
- `dec_pc`  out  32  head instruction address.
- `dec_ready`  in  1  decode accepts head.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its address is held in `req_pc`.
  - DROP: one request outstanding whose response must be discarded.
- Issue path (combinational):
  - `imem_req = (state==IDLE) && pc_valid && (count<DEPTH) && !flush && !reset`.
  - `imem_addr = pc_addr`.
  - `pc_ready = imem_req && imem_gnt`.
- Transitions:
  - IDLE→WAIT on `imem_req && imem_gnt`; `req_pc <= pc_addr`.
  - WAIT→IDLE on `imem_rvalid && !flush`; push `{req_pc, imem_rdata}`.
  - WAIT→IDLE on `imem_rvalid && flush`; response dropped.
  - WAIT→DROP on `flush && !imem_rvalid`.
  - DROP→IDLE on `imem_rvalid`; data discarded. Further `flush` pulses while in DROP have no additional effect.
- `imem_rvalid` is ignored in IDLE.
- FIFO behaviour:
  - Circular buffer: `wr_ptr`/`rd_ptr` are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits.
  - Pop on `dec_valid && dec_ready`. Push and pop in the same cycle leave `count` unchanged.
  - Only one request is ever outstanding, and issue requires `count<DEPTH`, so a push never overflows.
- Outputs:
  - `dec_valid = (count!=0)`.
  - `dec_inst`/`dec_pc` come from the head entry; they are forced to 0 when `dec_valid=0`.
- `flush`:
  - Synchronously clears `count`, `wr_ptr`, `rd_ptr`.
  - Suppresses both push and pop that cycle, and blocks issue that cycle.
- Reset:
  - State IDLE, pointers and count 0, `req_pc` 0.
  - All outputs 0 while `reset` is high. FIFO storage is not reset.
  - Reset mid-WAIT abandons the request; a later stray `imem_rvalid` arrives in IDLE and is ignored.

## Timing
- Issue: same cycle as `pc_valid` when IDLE, with space available and `imem_gnt` high.
- Memory response latency: ≥1 cycle after grant.
- Push: occurs on the `imem_rvalid` edge; `dec_valid` rises the next cycle.
- Minimum latency: grant at cycle N, rvalid at N+1, `dec_valid` at N+2.
- Throughput: at most one fetch per 2 cycles. A new issue is possible in the cycle after the response.
- `pc_ready` depends combinationally on `imem_gnt`; `imem_req` depends combinationally on `pc_valid`/`flush`.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - In WAIT, if `count==0 && imem_rvalid && !flush`, then `dec_valid=1`, `dec_inst=imem_rdata`, `dec_pc=req_pc` in the same cycle.
  - If `dec_ready` is also high, the entry is consumed and not pushed; otherwise it is pushed normally.
  - Minimum latency becomes rvalid-cycle.
- Undefined: no bypass; all entries pass through the FIFO (latency as in Timing).

## Test plan
- Reset, then `pc_valid=1`, `pc_addr=0x00`, `gnt=1`, 1-cycle memory returning `0xDEADBEEF` -> `dec_valid` with `dec_pc=0x00`, `dec_inst=0xDEADBEEF` two cycles after grant; `pc_ready` pulses once per 2 cycles.
- `dec_ready=0`, sequential fetches 0x00, 0x04, 0x08, 0x0C -> after 4 pushes `count=4`, `imem_req` stays 0. Then `dec_ready=1` -> entries drain in order; fetch of 0x10 resumes once `count<4`.
- `imem_gnt=0` for 3 cycles -> `imem_req` held with `imem_addr=0x20`, `pc_ready=0`; on grant `pc_ready=1` for exactly one cycle.
- Flush while in WAIT with memory latency 3, 2 entries queued -> `count=0` next cycle, state DROP; late response `0x12345678` never appears on `dec_inst`; next fetch of 0x100 is delivered correctly.
- Flush in the same cycle as `imem_rvalid` -> response dropped, state IDLE, `dec_valid=0`. Assert `reset` mid-WAIT -> all outputs 0 immediately; a stray rvalid after release is ignored.
- With `FETCH_BYPASS_EN`: empty queue, `dec_ready=1`, rvalid `0xCAFEF00D` at cycle N -> `dec_valid=1` at N, `count` stays 0.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - single-outstanding instruction fetch with decode FIFO
//
// Takes the next instruction address from the program counter, issues one
// request at a time to instruction memory, and queues returned {pc, inst}
// pairs for decode. A flush discards the queue and any response in flight.
//
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   pc_addr/pc_valid/pc_ready next address from the PC; PC advances on valid&&ready
//   imem_req/imem_addr        memory request and its address
//   imem_gnt                  memory accepted the request
//   imem_rvalid/imem_rdata    memory response
//   flush                     redirect: drop queue and in-flight response
//   dec_valid/dec_inst/dec_pc head entry presented to decode
//   dec_ready                 decode consumes the head entry
//
// Parameter DEPTH: FIFO entries, power of two, >= 2.
// Build option FETCH_BYPASS_EN: a response arriving while the queue is empty
// is presented to decode in the same cycle and is not queued if consumed.

module inst_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   req_pc;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic fifo_empty;
  logic fifo_full;
  logic rsp_take;
  logic bypass_vld;
  logic push;
  logic pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  // Issue only with room for the answer, so a response can always be queued.
  assign imem_req  = (state == IDLE) && pc_valid && !fifo_full && !flush && !reset;
  assign imem_addr = reset ? 32'h0 : pc_addr;
  assign pc_ready  = imem_req && imem_gnt;

  // A response is kept only if it belongs to a live (non-flushed) request.
  assign rsp_take = (state == WAIT) && imem_rvalid && !flush;

`ifdef FETCH_BYPASS_EN
  assign bypass_vld = rsp_take && fifo_empty && !reset;
`else
  assign bypass_vld = 1'b0;
`endif

  assign dec_valid = !reset && (!fifo_empty || bypass_vld);

  always_comb begin
    dec_pc   = 32'h0;
    dec_inst = 32'h0;
    if (dec_valid) begin
      if (!fifo_empty) begin
        dec_pc   = fifo_pc[rd_ptr];
        dec_inst = fifo_inst[rd_ptr];
      end else begin
        dec_pc   = req_pc;
        dec_inst = imem_rdata;
      end
    end
  end

  // A bypassed response that decode takes immediately never enters the FIFO.
  assign push = rsp_take && !(bypass_vld && dec_ready);
  assign pop  = !fifo_empty && dec_ready && !flush;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (imem_req && imem_gnt) state_nxt = WAIT;
      WAIT: begin
        if (imem_rvalid) state_nxt = IDLE;
        else if (flush)  state_nxt = DROP;
      end
      DROP: if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      req_pc <= 32'h0;
    end else begin
      state <= state_nxt;
      if (pc_ready) req_pc <= pc_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= req_pc;
      fifo_inst[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue

module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .flush(flush),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched pairs plus the one outstanding request.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        mq[$];
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_req_pc;

  logic        exp_req, exp_prdy, exp_dv, exp_byp;
  logic [31:0] exp_addr, exp_pc, exp_inst;
  logic        act_req, act_prdy, act_dv;
  logic [31:0] act_addr, act_pc, act_inst;

  task automatic predict();
    int n;
    n        = mq.size();
    exp_req  = !reset && !m_out && pc_valid && (n < DEPTH) && !flush;
    exp_prdy = exp_req && imem_gnt;
    exp_byp  = BYP && !reset && m_out && !m_drop && imem_rvalid && !flush && (n == 0);
    exp_dv   = !reset && ((n > 0) || exp_byp);
    exp_addr = reset ? 32'h0 : pc_addr;
    exp_pc   = 32'h0;
    exp_inst = 32'h0;
    if (exp_dv) begin
      if (n > 0) begin
        exp_pc   = mq[0].pc;
        exp_inst = mq[0].inst;
      end else begin
        exp_pc   = m_req_pc;
        exp_inst = imem_rdata;
      end
    end
  endtask

  task automatic model_update();
    bit resp, taken_direct;
    if (reset) begin
      mq.delete();
      m_out = 0; m_drop = 0; m_req_pc = 32'h0;
    end else if (flush) begin
      mq.delete();
      if (m_out) begin
        if (imem_rvalid) m_out = 0;
        else m_drop = 1;
      end
    end else begin
      resp = m_out && imem_rvalid;
      taken_direct = 0;
      if (exp_dv && dec_ready) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else taken_direct = 1;
      end
      if (resp && !m_drop && !taken_direct) mq.push_back('{m_req_pc, imem_rdata});
      if (resp) begin
        m_out = 0; m_drop = 0;
      end
      if (exp_prdy) begin
        m_out = 1; m_drop = 0; m_req_pc = pc_addr;
      end
    end
  endtask

  task automatic tick(input bit use_model);
    @(negedge clk);
    predict();
    act_req = imem_req; act_prdy = pc_ready; act_addr = imem_addr;
    act_dv = dec_valid; act_pc = dec_pc; act_inst = dec_inst;
    if (use_model) begin
      chk("m_imem_req", act_req, exp_req);
      chk("m_pc_ready", act_prdy, exp_prdy);
      chk("m_imem_addr", act_addr, exp_addr);
      chk("m_dec_valid", act_dv, exp_dv);
      chk("m_dec_pc", act_pc, exp_pc);
      chk("m_dec_inst", act_inst, exp_inst);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Memory responder: one response mem_lat cycles after each grant.
  int          lat_left = 0;
  int          mem_lat  = 1;
  logic [31:0] mdata, next_data;

  task automatic mem_prep();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (lat_left > 0) begin
      lat_left--;
      if (lat_left == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mdata;
      end
    end
  endtask

  task automatic mem_post();
    if (act_prdy) begin
      lat_left = mem_lat;
      mdata    = next_data;
    end
  endtask

  task automatic rtick();
    mem_prep();
    tick(1);
    mem_post();
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] pa;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        dr;
    logic        req;
    logic        prdy;
    logic        dv;
    logic [31:0] dpc;
    logic [31:0] dinst;
  } vec_t;
  vec_t tv[7];

  logic [31:0] next_pc;
  logic [31:0] popped[$];
  int          cnt;
  bit          flag_a, flag_b;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1,  1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
    tv[1] = '{1'b1, 32'h4, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1,
              1'b0, 1'b0, BYP, 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
    tv[2] = '{1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 1'b1,
              1'b1, 1'b1, !BYP, 32'h0, BYP ? 32'h0 : 32'hDEADBEEF};
    tv[3] = '{1'b1, 32'h8, 1'b1, 1'b1, 32'h11111111, 1'b1,
              1'b0, 1'b0, BYP, BYP ? 32'h4 : 32'h0, BYP ? 32'h11111111 : 32'h0};
    tv[4] = '{1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b1,
              1'b1, 1'b1, !BYP, BYP ? 32'h0 : 32'h4, BYP ? 32'h0 : 32'h11111111};
    tv[5] = '{1'b0, 32'hC, 1'b0, 1'b1, 32'h22222222, 1'b1,
              1'b0, 1'b0, BYP, BYP ? 32'h8 : 32'h0, BYP ? 32'h22222222 : 32'h0};
    tv[6] = '{1'b0, 32'hC, 1'b0, 1'b0, 32'h0, 1'b1,
              1'b0, 1'b0, !BYP, BYP ? 32'h0 : 32'h8, BYP ? 32'h0 : 32'h22222222};

    m_out = 0; m_drop = 0; m_req_pc = 32'h0;
    reset = 1'b1; pc_addr = 32'h44; pc_valid = 1'b1; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; flush = 1'b0; dec_ready = 1'b1;
    next_data = 32'h0; mdata = 32'h0;

    // Reset state: all outputs low even with pc_valid high.
    tick(1);
    chk("reset_imem_req", act_req, 32'h0);
    chk("reset_imem_addr", act_addr, 32'h0);
    chk("reset_dec_valid", act_dv, 32'h0);
    tick(1);
    reset = 1'b0; pc_valid = 1'b0; pc_addr = 32'h0;

    // Table: 1-cycle memory, pc_ready once per 2 cycles, dec_valid 2 cycles after grant.
    for (int i = 0; i < 7; i++) begin
      pc_valid = tv[i].pv; pc_addr = tv[i].pa; imem_gnt = tv[i].gnt;
      imem_rvalid = tv[i].rv; imem_rdata = tv[i].rd; dec_ready = tv[i].dr;
      tick(0);
      chk($sformatf("tv%0d_imem_req", i), act_req, tv[i].req);
      chk($sformatf("tv%0d_pc_ready", i), act_prdy, tv[i].prdy);
      chk($sformatf("tv%0d_dec_valid", i), act_dv, tv[i].dv);
      chk($sformatf("tv%0d_dec_pc", i), act_pc, tv[i].dpc);
      chk($sformatf("tv%0d_dec_inst", i), act_inst, tv[i].dinst);
    end
    imem_rvalid = 1'b0;

    // Fill to DEPTH with decode stalled, then drain in order.
    dec_ready = 1'b0; pc_valid = 1'b1; imem_gnt = 1'b1; mem_lat = 1; next_pc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      pc_addr = next_pc; next_data = 32'h1000_0000 | next_pc;
      rtick();
      if (act_prdy) next_pc += 32'h4;
    end
    chk("fill_count", 32'(dut.count), 32'd4);
    chk("fill_req_blocked", act_req, 32'h0);
    dec_ready = 1'b1; flag_a = 0;
    for (int i = 0; i < 14; i++) begin
      pc_addr = next_pc; next_data = 32'h1000_0000 | next_pc;
      rtick();
      if (act_dv) popped.push_back(act_pc);
      if (act_prdy && act_addr == 32'h10) flag_a = 1;
      if (act_prdy) next_pc += 32'h4;
    end
    while (popped.size() < 4) popped.push_back(32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) chk($sformatf("drain_order%0d", i), popped[i], 32'(i * 4));
    chk("resume_fetch_0x10", 32'(flag_a), 32'd1);
    pc_valid = 1'b0;
    for (int i = 0; i < 6; i++) rtick();

    // Grant withheld for 3 cycles.
    pc_valid = 1'b1; pc_addr = 32'h20; imem_gnt = 1'b0; cnt = 0;
    for (int i = 0; i < 3; i++) begin
      rtick();
      chk("nognt_req", act_req, 32'h1);
      chk("nognt_addr", act_addr, 32'h20);
      chk("nognt_pc_ready", act_prdy, 32'h0);
    end
    imem_gnt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rtick();
      if (act_prdy) cnt++;
      pc_addr = 32'h24;
    end
    chk("gnt_pc_ready_pulses", 32'(cnt), 32'd1);
    pc_valid = 1'b0;
    for (int i = 0; i < 4; i++) rtick();

    // Flush while waiting on a 3-cycle response with 2 entries queued.
    dec_ready = 1'b0; pc_valid = 1'b1; cnt = 0;
    for (int i = 0; i < 12 && cnt < 3; i++) begin
      mem_lat   = (cnt == 2) ? 3 : 1;
      next_data = (cnt == 2) ? 32'h12345678 : 32'hA000_0000 + 32'(cnt);
      pc_addr   = 32'h40 + 32'(cnt * 4);
      rtick();
      if (act_prdy) cnt++;
    end
    chk("flush_setup_grants", 32'(cnt), 32'd3);
    chk("flush_setup_count", 32'(dut.count), 32'd2);
    flush = 1'b1; pc_addr = 32'h100;
    rtick();
    flush = 1'b0; dec_ready = 1'b1; mem_lat = 1; next_data = 32'hA5A50100;
    chk("flush_count_cleared", 32'(dut.count), 32'd0);
    rtick();
    chk("drop_no_issue", act_req, 32'h0);
    flag_a = 0; flag_b = 0;
    for (int i = 0; i < 8; i++) begin
      rtick();
      if (act_dv && act_inst == 32'h12345678) flag_a = 1;
      if (act_dv && act_pc == 32'h100 && act_inst == 32'hA5A50100) flag_b = 1;
      if (act_prdy) pc_valid = 1'b0;
    end
    chk("flushed_resp_hidden", 32'(flag_a), 32'd0);
    chk("refetch_0x100", 32'(flag_b), 32'd1);

    // Flush in the same cycle as the response.
    pc_valid = 1'b1; pc_addr = 32'h200; mem_lat = 2; next_data = 32'h5555AAAA;
    cnt = 0;
    for (int i = 0; i < 4 && cnt == 0; i++) begin
      rtick();
      if (act_prdy) cnt = 1;
    end
    pc_valid = 1'b0; flag_a = 0;
    for (int i = 0; i < 4 && !flag_a; i++) begin
      mem_prep();
      flush = imem_rvalid;
      tick(1);
      mem_post();
      if (flush) begin
        flag_a = 1;
        chk("flush_rv_dec_valid", act_dv, 32'h0);
      end
      flush = 1'b0;
    end
    chk("flush_rv_seen", 32'(flag_a), 32'd1);
    pc_valid = 1'b1; pc_addr = 32'h204; mem_lat = 1;
    rtick();
    chk("flush_rv_idle_issue", act_req, 32'h1);
    chk("flush_rv_dropped", act_dv, 32'h0);
    pc_valid = 1'b0;
    for (int i = 0; i < 4; i++) rtick();

    // Reset while waiting; a stray response afterwards is ignored.
    dec_ready = 1'b0; pc_valid = 1'b1; cnt = 0;
    for (int i = 0; i < 10 && cnt < 2; i++) begin
      mem_lat = (cnt == 1) ? 3 : 1;
      next_data = 32'hBEEF0000 + 32'(cnt);
      pc_addr = 32'h300 + 32'(cnt * 4);
      rtick();
      if (act_prdy) cnt++;
    end
    chk("rst_setup_dec_valid", dec_valid, 32'h1);
    reset = 1'b1; pc_addr = 32'h308;
    #1;
    chk("rst_async_imem_req", imem_req, 32'h0);
    chk("rst_async_imem_addr", imem_addr, 32'h0);
    chk("rst_async_pc_ready", pc_ready, 32'h0);
    chk("rst_async_dec_valid", dec_valid, 32'h0);
    chk("rst_async_dec_pc", dec_pc, 32'h0);
    chk("rst_async_dec_inst", dec_inst, 32'h0);
    rtick();
    reset = 1'b0; pc_valid = 1'b0; dec_ready = 1'b1; flag_a = 0;
    for (int i = 0; i < 5; i++) begin
      mem_prep();
      if (imem_rvalid) flag_a = 1;
      tick(1);
      mem_post();
      chk("stray_rvalid_ignored", act_dv, 32'h0);
    end
    chk("stray_rvalid_seen", 32'(flag_a), 32'd1);

`ifdef FETCH_BYPASS_EN
    // Bypass: response shown to decode in its own cycle, nothing queued.
    pc_valid = 1'b1; pc_addr = 32'h400; mem_lat = 1; next_data = 32'hCAFEF00D; cnt = 0;
    for (int i = 0; i < 4 && cnt == 0; i++) begin
      rtick();
      if (act_prdy) cnt = 1;
    end
    pc_valid = 1'b0;
    mem_prep();
    tick(1);
    mem_post();
    chk("bypass_dec_valid", act_dv, 32'h1);
    chk("bypass_dec_inst", act_inst, 32'hCAFEF00D);
    chk("bypass_dec_pc", act_pc, 32'h400);
    chk("bypass_count", 32'(dut.count), 32'd0);
`endif

    // Randomized traffic against the model.
    next_pc = 32'h1000;
    for (int i = 0; i < 1500; i++) begin
      pc_valid  = ($urandom_range(0, 3) != 0);
      imem_gnt  = ($urandom_range(0, 9) < 7);
      dec_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      mem_lat   = $urandom_range(1, 4);
      next_data = $urandom;
      pc_addr   = next_pc;
      rtick();
      if (act_prdy) next_pc += 32'h4;
      if (flush) next_pc = $urandom & 32'h0000FFFC;
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
